// File: rtl/cpsr_forward_pipe.sv
// CPSR forwarding unit: tracks in-flight CPSR writers, forwards the youngest value and stalls readers.
// Optional stall-cycle counter is enabled by defining CPSR_FWD_STATS_EN.
module cpsr_forward_pipe #(
    parameter int         WIDTH      = 32,
    parameter int         STAGES     = 3,
    parameter logic [4:0] MODE_USER  = 5'b10000,
    parameter logic [4:0] MODE_RESET = 5'b10011,
    localparam int        CNT_W      = $clog2(STAGES + 1)
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [WIDTH-1:0]          in_CPSR_Arch,
    input  logic [STAGES*WIDTH-1:0]   in_StageCPSR,
    input  logic [STAGES-1:0]         in_StageReady,
    input  logic                      in_Advance,
    input  logic                      in_Flush,
    input  logic                      in_IssueValid,
    input  logic                      in_IssueWritesCPSR,
    input  logic                      in_IssueReadsCPSR,
    output logic [WIDTH-1:0]          out_CPSR_Fresh,
    output logic                      out_IsInPrivilegedMode,
    output logic                      out_Stall,
    output logic                      out_ModeChanged,
`ifdef CPSR_FWD_STATS_EN
    output logic [CNT_W-1:0]          out_PendingCount,
    output logic [15:0]               out_StallCycles
`else
    output logic [CNT_W-1:0]          out_PendingCount
`endif
);

    // Issue handshake: an issue is taken only when in_IssueValid=1, out_Stall=0 and
    // in_Advance=1; out_Stall is a combinational function of the issue fields, so the
    // issuer must not make in_IssueValid depend on out_Stall.

    logic [STAGES-1:0] pend;
    logic [STAGES-1:0] pendShift;
    logic [4:0]        r_LastMode;
    logic              r_ModeChanged;

    logic [WIDTH-1:0]  freshVal;
    logic              freshReady;
    logic              anyPend;
    logic [CNT_W-1:0]  pendCount;
    logic              captureWriter;

    // Descending scan so the lowest (youngest) pending stage is the one left selected.
    always_comb begin
        freshVal   = in_CPSR_Arch;
        freshReady = 1'b1;
        anyPend    = 1'b0;
        for (int i = STAGES - 1; i >= 0; i--) begin
            if (pend[i]) begin
                freshVal   = in_StageCPSR[i*WIDTH +: WIDTH];
                freshReady = in_StageReady[i];
                anyPend    = 1'b1;
            end
        end
    end

    always_comb begin
        pendCount = '0;
        for (int i = 0; i < STAGES; i++) begin
            pendCount = pendCount + CNT_W'(pend[i]);
        end
    end

    assign out_Stall = ~reset & in_IssueValid & in_IssueReadsCPSR & anyPend & ~freshReady;
    assign out_CPSR_Fresh         = reset ? in_CPSR_Arch : freshVal;
    assign out_IsInPrivilegedMode = (out_CPSR_Fresh[4:0] != MODE_USER);
    assign out_ModeChanged        = ~reset & r_ModeChanged;
    assign out_PendingCount       = reset ? '0 : pendCount;

    assign captureWriter = in_IssueValid & in_IssueWritesCPSR & ~out_Stall;

    always_comb begin
        pendShift    = '0;
        pendShift[0] = captureWriter;
        for (int i = 1; i < STAGES; i++) begin
            pendShift[i] = pend[i-1];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pend <= '0;
        end else if (in_Flush) begin
            pend <= '0;
        end else if (in_Advance) begin
            pend <= pendShift;
        end
    end

    // Mode tracking freezes while stalled so a not-yet-valid value cannot fake a change.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_LastMode    <= MODE_RESET;
            r_ModeChanged <= 1'b0;
        end else if (!out_Stall) begin
            r_LastMode    <= out_CPSR_Fresh[4:0];
            r_ModeChanged <= (out_CPSR_Fresh[4:0] != r_LastMode);
        end else begin
            r_ModeChanged <= 1'b0;
        end
    end

`ifdef CPSR_FWD_STATS_EN
    logic [15:0] stallCycles;

    always_ff @(posedge clock) begin
        if (reset) begin
            stallCycles <= '0;
        end else if (out_Stall && (stallCycles != 16'hFFFF)) begin
            stallCycles <= stallCycles + 16'd1;
        end
    end

    assign out_StallCycles = stallCycles;
`endif

endmodule

// File: tb/tb_cpsr_forward_pipe.sv
// Self-checking bench for cpsr_forward_pipe: directed scenarios followed by random traffic,
// with a behavioural model feeding an expected-value queue each cycle.
module tb_cpsr_forward_pipe;

    localparam int W  = 32;
    localparam int S  = 3;
    localparam int EW = 53;   // {fresh[31:0], priv, stall, modeChanged, count[1:0], stats[15:0]}

    logic           clock;
    logic           reset;
    logic [W-1:0]   arch;
    logic [S*W-1:0] stg;
    logic [S-1:0]   rdy;
    logic           adv;
    logic           flush;
    logic           iv;
    logic           iw;
    logic           ir;

    logic [W-1:0]   dutFresh;
    logic           dutPriv;
    logic           dutStall;
    logic           dutModeChanged;
    logic [1:0]     dutCount;
    logic [15:0]    dutStats;

    cpsr_forward_pipe #(.WIDTH(W), .STAGES(S)) dut (
        .clock                  (clock),
        .reset                  (reset),
        .in_CPSR_Arch           (arch),
        .in_StageCPSR           (stg),
        .in_StageReady          (rdy),
        .in_Advance             (adv),
        .in_Flush               (flush),
        .in_IssueValid          (iv),
        .in_IssueWritesCPSR     (iw),
        .in_IssueReadsCPSR      (ir),
        .out_CPSR_Fresh         (dutFresh),
        .out_IsInPrivilegedMode (dutPriv),
        .out_Stall              (dutStall),
        .out_ModeChanged        (dutModeChanged),
`ifdef CPSR_FWD_STATS_EN
        .out_PendingCount       (dutCount),
        .out_StallCycles        (dutStats)
`else
        .out_PendingCount       (dutCount)
`endif
    );

`ifndef CPSR_FWD_STATS_EN
    assign dutStats = 16'h0;
`endif

    // Clock
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Model state
    logic [S-1:0] mPend;
    logic [4:0]   mLast;
    logic         mMc;
    logic [15:0]  mStallCnt;

    logic [EW-1:0] expQ[$];
    int errCount   = 0;
    int checkCount = 0;

    task automatic checkVal(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checkCount++;
        if (obs !== exp) begin
            errCount++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One cycle: settle, predict, compare, then advance model with the clock edge.
    task automatic tick();
        logic [W-1:0]  eFresh;
        logic          eRdy;
        logic          eAny;
        logic          eStall;
        logic [1:0]    eCnt;
        logic          ePriv;
        logic          eMc;
        logic [EW-1:0] ent;
        logic [S-1:0]  nPend;
        #2;
        eFresh = arch;
        eRdy   = 1'b1;
        eAny   = 1'b0;
        for (int i = 0; i < S; i++) begin
            if (mPend[i] && !eAny) begin
                eFresh = stg[i*W +: W];
                eRdy   = rdy[i];
                eAny   = 1'b1;
            end
        end
        if (reset) eFresh = arch;
        eStall = !reset && iv && ir && eAny && !eRdy;
        eCnt   = 2'd0;
        if (!reset) eCnt = 2'(mPend[0]) + 2'(mPend[1]) + 2'(mPend[2]);
        ePriv  = (eFresh[4:0] != 5'b10000);
        eMc    = !reset && mMc;
        expQ.push_back({eFresh, ePriv, eStall, eMc, eCnt, mStallCnt});

        ent = expQ.pop_front();
        checkVal("fresh", 64'(dutFresh), 64'(ent[52:21]));
        checkVal("priv", 64'(dutPriv), 64'(ent[20]));
        checkVal("stall", 64'(dutStall), 64'(ent[19]));
        checkVal("modeChanged", 64'(dutModeChanged), 64'(ent[18]));
        checkVal("pendCount", 64'(dutCount), 64'(ent[17:16]));
`ifdef CPSR_FWD_STATS_EN
        checkVal("stallCycles", 64'(dutStats), 64'(ent[15:0]));
`endif

        nPend = mPend;
        if (flush) nPend = '0;
        else if (adv) nPend = {mPend[1:0], iv & iw & ~eStall};

        @(posedge clock);
        if (reset) begin
            mPend     = '0;
            mLast     = 5'b10011;
            mMc       = 1'b0;
            mStallCnt = 16'h0;
        end else begin
            mPend = nPend;
            if (!eStall) begin
                mMc   = (eFresh[4:0] != mLast);
                mLast = eFresh[4:0];
            end else begin
                mMc = 1'b0;
            end
            if (eStall && mStallCnt != 16'hFFFF) mStallCnt = mStallCnt + 16'd1;
        end
        #1;
    endtask

    task automatic driveIdle();
        adv = 1'b0; flush = 1'b0; iv = 1'b0; iw = 1'b0; ir = 1'b0;
    endtask

    task automatic driveWriter(input logic advance);
        iv = 1'b1; iw = 1'b1; ir = 1'b0; adv = advance; flush = 1'b0;
    endtask

    initial begin
        mPend = '0; mLast = 5'b10011; mMc = 1'b0; mStallCnt = 16'h0;
        reset = 1'b1;
        arch  = 32'h6000_001F;
        stg   = '0;
        rdy   = '0;
        driveIdle();
        tick();
        tick();
        reset = 1'b0;

        // T1 idle: architectural value passes through, privileged
        tick();
        tick();

        // T2 forward a user-mode value from stage 0
        driveWriter(1'b1);
        tick();
        driveIdle();
        stg[0 +: W] = 32'h8000_0010;
        rdy = 3'b001;
        tick();
        tick();
        tick();

        // T3 reader behind a not-ready writer stalls, then releases
        iv = 1'b1; ir = 1'b1; iw = 1'b0; adv = 1'b0;
        rdy = 3'b000;
        tick();
        tick();
        rdy = 3'b001;
        tick();
        driveIdle();
        flush = 1'b1;
        tick();

        // T4 youngest pending writer wins over an older ready one
        driveWriter(1'b1);
        tick();
        driveIdle();
        adv = 1'b1;
        tick();
        driveWriter(1'b1);
        tick();
        driveIdle();
        stg = {32'h0000_0002, 32'h0000_00AA, 32'h0000_0001};
        rdy = 3'b111;
        tick();

        // T5 retire through all stages, then flush beats a simultaneous issue
        flush = 1'b1;
        tick();
        driveWriter(1'b1);
        tick();
        driveIdle();
        adv = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        tick();
        driveWriter(1'b1);
        tick();
        flush = 1'b1;
        tick();
        driveIdle();
        tick();

        // T6 reset mid-operation with a stall accumulated
        for (int i = 0; i < 3; i++) begin
            driveWriter(1'b1);
            tick();
        end
        driveIdle();
        rdy = 3'b000;
        iv = 1'b1; ir = 1'b1;
        tick();
        tick();
        driveIdle();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        tick();

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            reset = ($urandom_range(0, 59) == 0);
            arch  = $urandom;
            if ($urandom_range(0, 1) == 1) arch[4:0] = 5'b10000;
            stg   = {$urandom, $urandom, $urandom};
            if ($urandom_range(0, 1) == 1) stg[4:0] = 5'b10000;
            rdy   = 3'($urandom_range(0, 7));
            adv   = ($urandom_range(0, 3) != 0);
            flush = ($urandom_range(0, 15) == 0);
            iv    = 1'($urandom_range(0, 1));
            iw    = 1'($urandom_range(0, 1));
            ir    = 1'($urandom_range(0, 1));
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errCount, checkCount);
        $finish;
    end

endmodule
